// File: rtl/lateral_inhibit_h1_pkg.sv
// Shared definitions for the hidden-layer-1 lateral-inhibition arbiter:
// FSM encodings, default widths and the spike threshold.
package lateral_inhibit_h1_pkg;

  localparam int LI_W  = 24;     // potential width, signed Q12
  localparam int LI_N3 = 3;      // index width for the default 8 neurons
  localparam int LI_TH = 15018;  // 3.6667 in Q12

  typedef enum logic [1:0] {
    LI_IDLE    = 2'd0,
    LI_COLLECT = 2'd1,
    LI_SCAN    = 2'd2,
    LI_RESPOND = 2'd3
  } li_state_t;

endpackage

// File: rtl/lateral_inhibit_h1_max_scan.sv
// li_max_scan_h1: sequential signed max-finder, one candidate per cycle while en is high.
// res_idx/res_pot show the running best including the current candidate, so they are final when done pulses.
module li_max_scan_h1
  import lateral_inhibit_h1_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = LI_W,
  parameter int IW = LI_N3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cand_req,
  input  logic signed [W-1:0] cand_pot,
  output logic [IW-1:0]       k,
  output logic                done,
  output logic [IW-1:0]       res_idx,
  output logic signed [W-1:0] res_pot
);

  logic [IW-1:0]       k_q, k_d;
  logic [IW-1:0]       best_idx_q, best_idx_d;
  logic signed [W-1:0] best_pot_q, best_pot_d;
  logic                have_q, have_d;
  logic                last;
  logic                take;

  always_comb begin
    last = (k_q == IW'(N - 1));
    // Strict compare keeps the lowest index on ties.
    take = en && cand_req && (!have_q || (cand_pot > best_pot_q));
    k_d = '0;
    if (en && !last) begin
      k_d = k_q + 1'b1;
    end
    have_d     = en && (have_q || take);
    best_idx_d = take ? k_q : best_idx_q;
    best_pot_d = take ? cand_pot : best_pot_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q        <= '0;
      best_idx_q <= '0;
      best_pot_q <= '0;
      have_q     <= 1'b0;
    end else begin
      k_q        <= k_d;
      best_idx_q <= best_idx_d;
      best_pot_q <= best_pot_d;
      have_q     <= have_d;
    end
  end

  assign k       = k_q;
  assign done    = en && last;
  assign res_idx = best_idx_d;
  assign res_pot = best_pot_d;

endmodule

// File: rtl/lateral_inhibit_h1.sv
// lateral_inhibit_h1: collects start_li requests, scans for the highest potential and answers with valid_li/won_lost.
// Define LI_TIMEOUT_EN to let COLLECT give up after TIMEOUT cycles and scan the partial request set.
module lateral_inhibit_h1
  import lateral_inhibit_h1_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = LI_W,
  parameter int TH      = LI_TH,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_core_img,
  input  logic [N-1:0]   active_mask,
  input  logic [N-1:0]   start_li,
  input  logic [N*W-1:0] potential,
  output logic [N-1:0]   valid_li,
  output logic [N-1:0]   won_lost,
  output logic           li,
  output logic           busy,
  output logic           err_drop
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [W-1:0] TH_W = W'(TH);

  li_state_t           state_q, state_d;
  logic [N-1:0]        req_hold_q, req_hold_d;
  logic signed [W-1:0] pot_hold_q [N];
  logic signed [W-1:0] pot_hold_d [N];
  logic signed [W-1:0] pot_in     [N];
  logic [N-1:0]        valid_li_q, valid_li_d;
  logic [N-1:0]        won_lost_q, won_lost_d;
  logic                li_q, li_d;
  logic                err_drop_q, err_drop_d;

  logic                scan_en, scan_done;
  logic [IW-1:0]       scan_k, res_idx;
  logic signed [W-1:0] res_pot;
  logic [N-1:0]        res_onehot;
  logic                collecting, covered, tmo_hit;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign pot_in[gi]     = potential[gi*W +: W];
    assign res_onehot[gi] = (res_idx == IW'(gi));
  end

  assign collecting = (state_q == LI_IDLE) || (state_q == LI_COLLECT);
  // Coverage includes this cycle's requests so the last one can close the window immediately.
  assign covered    = (((req_hold_q | start_li) & active_mask) == active_mask);
  assign scan_en    = (state_q == LI_SCAN);

`ifdef LI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (state_q == LI_COLLECT) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = (state_q == LI_COLLECT) && (tmo_q == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign tmo_hit        = 1'b0;
`endif

  li_max_scan_h1 #(
    .N  (N),
    .W  (W),
    .IW (IW)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .en       (scan_en),
    .cand_req (req_hold_q[scan_k]),
    .cand_pot (pot_hold_q[scan_k]),
    .k        (scan_k),
    .done     (scan_done),
    .res_idx  (res_idx),
    .res_pot  (res_pot)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LI_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LI_IDLE:    if (|start_li) state_d = covered ? LI_SCAN : LI_COLLECT;
      LI_COLLECT: if (covered || tmo_hit) state_d = LI_SCAN;
      LI_SCAN:    if (scan_done) state_d = LI_RESPOND;
      LI_RESPOND: state_d = LI_IDLE;
      default:    state_d = LI_IDLE;
    endcase
    if (start_core_img) begin
      state_d = LI_IDLE;
    end
  end

  // Responses are registered on the last SCAN edge so they appear during the RESPOND cycle.
  always_comb begin
    req_hold_d = req_hold_q;
    valid_li_d = '0;
    won_lost_d = won_lost_q;
    li_d       = li_q;
    err_drop_d = err_drop_q;
    for (int i = 0; i < N; i++) begin
      pot_hold_d[i] = pot_hold_q[i];
      if (collecting && start_li[i]) begin
        pot_hold_d[i] = pot_in[i];
      end
    end
    if (collecting) begin
      req_hold_d = req_hold_q | start_li;
    end
    if (!collecting && (|start_li)) begin
      err_drop_d = 1'b1;
    end
    if (state_q == LI_RESPOND) begin
      req_hold_d = '0;
    end
    if (scan_en && scan_done) begin
      valid_li_d = req_hold_q;
      won_lost_d = res_onehot;
      if (res_pot >= TH_W) begin
        li_d = 1'b1;
      end
    end
    if (start_core_img) begin
      req_hold_d = '0;
      valid_li_d = '0;
      won_lost_d = won_lost_q;
      li_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_hold_q <= '0;
      valid_li_q <= '0;
      won_lost_q <= '0;
      li_q       <= 1'b0;
      err_drop_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        pot_hold_q[i] <= '0;
      end
    end else begin
      req_hold_q <= req_hold_d;
      valid_li_q <= valid_li_d;
      won_lost_q <= won_lost_d;
      li_q       <= li_d;
      err_drop_q <= err_drop_d;
      for (int i = 0; i < N; i++) begin
        pot_hold_q[i] <= pot_hold_d[i];
      end
    end
  end

  assign valid_li = valid_li_q;
  assign won_lost = won_lost_q;
  assign li       = li_q;
  assign busy     = (state_q != LI_IDLE);
  assign err_drop = err_drop_q;

endmodule
